// File: rtl/sum_accumulator.sv
// Accumulates a valid/ready stream of adder sums into block totals of COUNT samples (or until flush).
// Optional build macro SUM_ACC_SATURATE_EN: clamp the total at 2^ACC_W-1 instead of wrapping.
module sum_accumulator #(
    parameter int unsigned SUM_W = 3,
    parameter int unsigned ACC_W = 8,
    parameter int unsigned COUNT = 4,
    parameter int unsigned CNT_W = $clog2(COUNT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SUM_W-1:0] sum_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    localparam int unsigned EXT_W = ACC_W + 1;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W-1:0] res_data_q, res_data_d;
    logic [CNT_W-1:0] res_count_q, res_count_d;
    logic             res_ovf_q, res_ovf_d;

    logic             in_ready_c;
    logic             accept_c;
    logic [EXT_W-1:0] sum_ext_c;
    logic             carry_c;
    logic [ACC_W-1:0] acc_add_c;
    logic [CNT_W-1:0] cnt_inc_c;
    logic             ovf_add_c;

    assign in_ready_c = (state_q == ST_ACCUM) && !rst;
    assign accept_c   = in_valid && in_ready_c;

    // Post-add values for the sample offered this cycle
    always_comb begin
        sum_ext_c = {1'b0, acc_q} + EXT_W'(sum_in);
        carry_c   = sum_ext_c[ACC_W];
        ovf_add_c = ovf_q || carry_c;
        cnt_inc_c = cnt_q + CNT_W'(1);
`ifdef SUM_ACC_SATURATE_EN
        acc_add_c = ovf_add_c ? {ACC_W{1'b1}} : sum_ext_c[ACC_W-1:0];
`else
        acc_add_c = sum_ext_c[ACC_W-1:0];
`endif
    end

    // Next-state: accumulate in ACCUM, hold the result until the output handshake
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        res_data_d  = res_data_q;
        res_count_d = res_count_q;
        res_ovf_d   = res_ovf_q;

        case (state_q)
            ST_ACCUM: begin
                if (accept_c) begin
                    acc_d = acc_add_c;
                    cnt_d = cnt_inc_c;
                    ovf_d = ovf_add_c;
                end
                if ((accept_c && (cnt_q == CNT_W'(COUNT - 1))) ||
                    (flush && ((cnt_q != '0) || accept_c))) begin
                    state_d     = ST_HOLD;
                    res_data_d  = acc_d;
                    res_count_d = cnt_d;
                    res_ovf_d   = ovf_d;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            res_data_q  <= '0;
            res_count_q <= '0;
            res_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            res_data_q  <= res_data_d;
            res_count_q <= res_count_d;
            res_ovf_q   <= res_ovf_d;
        end
    end

    assign in_ready  = in_ready_c;
    assign out_valid = (state_q == ST_HOLD);
    assign out_data  = res_data_q;
    assign out_count = res_count_q;
    assign out_ovf   = res_ovf_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed self-checking bench: default instance plus an ACC_W=4 instance sharing the same stimulus.
module tb_sum_accumulator;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [2:0] sum_in;
    logic       flush;
    logic       out_ready;

    logic       in_ready_a,  in_ready_b;
    logic       out_valid_a, out_valid_b;
    logic [7:0] out_data_a;
    logic [3:0] out_data_b;
    logic [2:0] out_count_a, out_count_b;
    logic       out_ovf_a,   out_ovf_b;

    int n_checks = 0;
    int n_fail   = 0;

    sum_accumulator #(.SUM_W(3), .ACC_W(8), .COUNT(4)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .sum_in(sum_in), .flush(flush), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_data(out_data_a), .out_count(out_count_a), .out_ovf(out_ovf_a)
    );

    sum_accumulator #(.SUM_W(3), .ACC_W(4), .COUNT(4)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .sum_in(sum_in), .flush(flush), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_data(out_data_b), .out_count(out_count_b), .out_ovf(out_ovf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] v);
        in_valid = 1'b1;
        sum_in   = v;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic check_result(input string tag, input int data, input int cnt, input int ovf);
        check_eq({tag, "_valid"}, 32'(out_valid_a), 32'd1);
        check_eq({tag, "_data"},  32'(out_data_a),  32'(data));
        check_eq({tag, "_count"}, 32'(out_count_a), 32'(cnt));
        check_eq({tag, "_ovf"},   32'(out_ovf_a),   32'(ovf));
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        sum_in    = 3'd3;
        flush     = 1'b0;
        out_ready = 1'b1;

        // Reset held with in_valid asserted
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("rst_in_ready", 32'(in_ready_a), 32'd0);
        end
        check_eq("rst_out_valid", 32'(out_valid_a), 32'd0);
        check_eq("rst_out_data",  32'(out_data_a),  32'd0);
        check_eq("rst_out_count", 32'(out_count_a), 32'd0);
        check_eq("rst_out_ovf",   32'(out_ovf_a),   32'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check_eq("post_rst_in_ready", 32'(in_ready_a), 32'd1);

        // Basic block 3+5+7+1
        send(3'd3);
        send(3'd5);
        send(3'd7);
        check_eq("basic_not_early", 32'(out_valid_a), 32'd0);
        send(3'd1);
        check_result("basic", 16, 4, 0);
        check_eq("basic_hold_in_ready", 32'(in_ready_a), 32'd0);
        tick();
        check_eq("basic_released", 32'(out_valid_a), 32'd0);
        check_eq("basic_ready_back", 32'(in_ready_a), 32'd1);

        // Backpressure: result held, input refused
        out_ready = 1'b0;
        send(3'd1);
        send(3'd2);
        send(3'd3);
        send(3'd4);
        in_valid = 1'b1;
        sum_in   = 3'd7;
        for (int i = 0; i < 5; i++) begin
            check_result("bp_hold", 10, 4, 0);
            check_eq("bp_in_ready", 32'(in_ready_a), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check_eq("bp_released", 32'(out_valid_a), 32'd0);
        send(3'd1);
        send(3'd1);
        send(3'd1);
        send(3'd1);
        check_result("bp_fresh", 4, 4, 0);
        tick();

        // Flush alone after 2,6
        send(3'd2);
        send(3'd6);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_result("flush_alone", 8, 2, 0);
        tick();

        // Flush together with the second sample
        send(3'd2);
        flush = 1'b1;
        send(3'd4);
        flush = 1'b0;
        check_result("flush_same", 6, 2, 0);
        tick();

        // Flush on an empty block is ignored
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("flush_empty_valid", 32'(out_valid_a), 32'd0);
        check_eq("flush_empty_ready", 32'(in_ready_a), 32'd1);
        tick();
        check_eq("flush_empty_valid2", 32'(out_valid_a), 32'd0);

        // Reset mid-block discards the partial sum
        send(3'd5);
        send(3'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("midrst_valid", 32'(out_valid_a), 32'd0);
        send(3'd1);
        send(3'd1);
        send(3'd1);
        send(3'd1);
        check_result("midrst", 4, 4, 0);
        tick();

        // Overflow on the 4-bit instance: 7,7,7,7
        send(3'd7);
        send(3'd7);
        send(3'd7);
        send(3'd7);
        check_result("ovf_wide", 28, 4, 0);
        check_eq("ovf_narrow_valid", 32'(out_valid_b), 32'd1);
`ifdef SUM_ACC_SATURATE_EN
        check_eq("ovf_narrow_data", 32'(out_data_b), 32'd15);
`else
        check_eq("ovf_narrow_data", 32'(out_data_b), 32'd12);
`endif
        check_eq("ovf_narrow_count", 32'(out_count_b), 32'd4);
        check_eq("ovf_narrow_flag",  32'(out_ovf_b),   32'd1);
        tick();

        // Overflow then a zero sample: clamp holds vs wrapped value
        send(3'd7);
        send(3'd7);
        send(3'd7);
        send(3'd0);
        check_result("ovf0_wide", 21, 4, 0);
`ifdef SUM_ACC_SATURATE_EN
        check_eq("ovf0_narrow_data", 32'(out_data_b), 32'd15);
`else
        check_eq("ovf0_narrow_data", 32'(out_data_b), 32'd5);
`endif
        check_eq("ovf0_narrow_flag", 32'(out_ovf_b), 32'd1);
        tick();

        // Fresh block after an overflow block has the flag cleared
        send(3'd1);
        send(3'd2);
        send(3'd3);
        send(3'd4);
        check_eq("clr_narrow_data", 32'(out_data_b), 32'd10);
        check_eq("clr_narrow_flag", 32'(out_ovf_b),  32'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sum_accumulator.md
# sum_accumulator

Downstream consumer of the 3-bit adder stage. Accepts a stream of SUM_W-bit sums over a valid/ready handshake and accumulates them into a wider ACC_W-bit register. After COUNT accepted samples, or on an explicit flush, it presents the total, the sample count and an overflow flag on a registered valid/ready output. It is the first clocked stage after the combinational adder and turns per-cycle sums into block totals.

## Interface

Parameters:
- SUM_W, 3 — width of incoming sum (matches adder output)
- ACC_W, 8 — accumulator/result width; must be ≥ SUM_W
- COUNT, 4 — samples per block; must be ≥ 1
- CNT_W, $clog2(COUNT+1) — width of sample counter/out_count

Ports:
- clk  in  1  — single clock, rising edge
- rst  in  1  — reset; synchronous, active-high
- in_valid  in  1  — sum_in valid
- in_ready  out  1  — stage can accept sum_in
- sum_in  in  SUM_W  — unsigned sum from adder
- flush  in  1  — close current block early
- out_valid  out  1  — result valid
- out_ready  in  1  — downstream accepts result
- out_data  out  ACC_W  — block total
- out_count  out  CNT_W  — samples in block
- out_ovf  out  1  — total exceeded ACC_W at some point in block

## Operation

- Two states: ACCUM, HOLD. Reset state ACCUM.
- in_ready = (state == ACCUM) && !rst; combinational from state only, never from in_valid.
- Accept = in_valid && in_ready. On accept: acc <= acc + zero-extended sum_in (mod 2^ACC_W); cnt <= cnt + 1; ovf sticky-set if carry out of bit ACC_W-1.
- ACCUM → HOLD when accept with cnt == COUNT-1, or flush with (cnt > 0 or accept). Result registers load the post-add values (the same-cycle sample is included).
- flush with cnt == 0 and no accept: ignored, no empty block emitted.
- HOLD: out_valid = 1, out_data/out_count/out_ovf stable; in_valid ignored, flush ignored.
- HOLD → ACCUM on out_valid && out_ready; acc, cnt, ovf cleared in the same edge.
- COUNT = 1: every accepted sample produces a block.
- Unsigned arithmetic only; no sign extension.

## Timing

- Reset values: out_valid 0, out_data 0, out_count 0, out_ovf 0, acc 0, cnt 0; in_ready 0 during rst, 1 on the first cycle after.
- Result latency: out_valid rises on the clock edge that accepts the last sample or flush, i.e. visible one cycle after that accept cycle.
- Output is a registered hold: values are unchanged while out_valid && !out_ready.
- Release-to-ready: in_ready is 1 the cycle after the out handshake (one bubble per block; no bypass).
- out_ready in HOLD together with in_valid in the same cycle: the input is not accepted (in_ready = 0).
- rst mid-block or in HOLD: partial/pending result is discarded and all registers take reset values on that edge.
- Throughput: COUNT samples per COUNT+1 cycles with out_ready held at 1.

## Configuration

- SUM_ACC_SATURATE_EN defined: on overflow, acc clamps to 2^ACC_W-1 and holds there for the rest of the block; out_ovf still set.
- Not defined: acc wraps modulo 2^ACC_W; out_ovf set.
- No other behaviour differs.

## Test plan

- Reset: hold rst 3 cycles with in_valid = 1 -> all outputs 0, in_ready 0; on the first cycle after reset, in_ready = 1 and no sample was absorbed.
- Basic block (defaults): feed 3,5,7,1 back-to-back, out_ready = 1 -> out_valid one cycle after the 4th accept with out_data 16, out_count 4, out_ovf 0; in_ready back to 1 the cycle after the handshake.
- Backpressure: out_ready = 0 for 5 cycles in HOLD while in_valid = 1 -> outputs stable, in_ready 0, nothing accepted; raise out_ready -> handshake, then the next sample starts a fresh block from 0.
- Overflow, ACC_W = 4, COUNT = 4: feed 7,7,7,7 -> wrap build out_data 12 (28 mod 16), out_ovf 1; SUM_ACC_SATURATE_EN build out_data 15, out_ovf 1.
- Flush: feed 2,6, then flush alone -> out_data 8, out_count 2; flush in the same cycle as accepting 4 after 2 -> out_data 6, out_count 2; flush with cnt 0 -> no out_valid.
- Reset mid-block: feed 5,5, assert rst, then feed 1,1,1,1 -> out_data 4, out_count 4 (earlier samples discarded).
